keycode_event_queue: RTL and testbench

Event-queue controller that sits behind the PS/2 keycode recognizer and its keypress buffer. It watches the buffer's sticky `got_one` flag, captures each completed key event as `{ext, make, keycode}`, and pulses `clear` to re-arm the buffer. Events are stored in a small FIFO and handed to a downstream consumer (CPU register port, display logic) over a valid/ready handshake. The block also tracks overflow when the consumer falls behind.

---
 rtl/keycode_event_queue.sv | 104 ++++++++++
 tb/tb_keycode_event_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keycode_event_queue.sv
// Captures completed PS/2 key events from the keypress buffer into a small
// first-word-fall-through FIFO, re-arms the buffer, and tracks dropped events.
module keycode_event_queue #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    keycode,
  input  logic          ext,
  input  logic          make,
  input  logic          got_one,
  output logic          clear,
  input  logic          ev_ready,
  output logic          ev_valid,
  output logic [7:0]    ev_keycode,
  output logic          ev_ext,
  output logic          ev_make,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          overflow_clr,
  output logic [7:0]    drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [9:0]    mem [DEPTH];

  logic full;
  logic capture;
  logic push;
  logic drop;
  logic pop;

  // Handshake: an entry transfers on any edge where ev_valid and ev_ready are
  // both 1; ev_valid never depends on ev_ready, and the head holds until popped.
  assign full     = (count == FULL_CNT);
  assign capture  = (state == ST_IDLE) && got_one;
  assign push     = capture && !full;
  assign drop     = capture && full;
  assign ev_valid = (count != '0);
  assign pop      = ev_valid && ev_ready;
  assign clear    = (state == ST_CLEAR);

  assign {ev_ext, ev_make, ev_keycode} = mem[rd_ptr];

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (got_one) state_next = ST_CLEAR;
      ST_CLEAR: state_next = ST_WAIT;
      ST_WAIT:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset; the head is don't-care while empty.
  always_ff @(posedge clk) begin
    if (reset_n && push) mem[wr_ptr] <= {ext, make, keycode};
  end

  // A drop in the same cycle as a clear request wins over the clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_clr)           drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed bench for keycode_event_queue: reset, capture/clear timing, FIFO
// ordering with wrap, overflow accounting and mid-sequence reset.
module tb_keycode_event_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset_n;
  logic [7:0]    keycode;
  logic          ext;
  logic          make;
  logic          got_one;
  logic          clear;
  logic          ev_ready;
  logic          ev_valid;
  logic [7:0]    ev_keycode;
  logic          ev_ext;
  logic          ev_make;
  logic [CW-1:0] count;
  logic          overflow;
  logic          overflow_clr;
  logic [7:0]    drop_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  keycode_event_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .keycode      (keycode),
    .ext          (ext),
    .make         (make),
    .got_one      (got_one),
    .clear        (clear),
    .ev_ready     (ev_ready),
    .ev_valid     (ev_valid),
    .ev_keycode   (ev_keycode),
    .ev_ext       (ev_ext),
    .ev_make      (ev_make),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_cnt     (drop_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: called at a negedge; models the keypress buffer (got_one drops once
  // clear is seen) and returns at the third negedge, so back-to-back calls
  // exercise the 1-event-per-3-cycles rate. Optionally pops or clears overflow
  // on the capture edge.
  task automatic send_event(input logic [7:0] kc, input logic e, input logic m,
                            input logic pop_at_cap, input logic clr_at_cap,
                            output int clear_cycles);
    clear_cycles = 0;
    keycode      = kc;
    ext          = e;
    make         = m;
    got_one      = 1'b1;
    ev_ready     = pop_at_cap;
    overflow_clr = clr_at_cap;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ev_ready     = 1'b0;
      overflow_clr = 1'b0;
      if (clear === 1'b1) begin
        clear_cycles++;
        got_one = 1'b0;
      end
    end
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  task automatic push_n(input logic [7:0] first, input int n);
    int cc;
    for (int i = 0; i < n; i++) begin
      send_event(first + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0, cc);
      exp_q.push_back(first + 8'(i));
    end
  endtask

  task automatic drain_and_check(input string name);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (ev_valid !== 1'b1 || ev_keycode !== e) begin
        errors++;
        $display("FAIL %s drain: valid=%b keycode=%h required valid=1 keycode=%h",
                 name, ev_valid, ev_keycode, e);
      end
      pop_one();
    end
    checks++;
    if (count !== '0 || ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s empty: count=%0d valid=%b required 0/0", name, count, ev_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; got_one = 1'b1; keycode = 8'hAA; ext = 1'b0; make = 1'b1;
    ev_ready = 1'b0; overflow_clr = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (clear !== 1'b0 || count !== '0 || ev_valid !== 1'b0 ||
          overflow !== 1'b0 || drop_cnt !== 8'd0) begin
        errors++;
        $display("FAIL reset: clear=%b count=%0d valid=%b ovf=%b drop=%0d required all 0",
                 clear, count, ev_valid, overflow, drop_cnt);
      end
    end
    reset_n = 1'b1;
    got_one = 1'b0;
  endtask

  task automatic test_single();
    int cc;
    send_event(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, cc);
    checks++;
    if (cc !== 1) begin
      errors++;
      $display("FAIL single clear pulse: cycles=%0d required 1", cc);
    end
    checks++;
    if (ev_valid !== 1'b1 || ev_keycode !== 8'h1C || ev_make !== 1'b1 ||
        ev_ext !== 1'b0 || count !== CW'(1)) begin
      errors++;
      $display("FAIL single head: valid=%b kc=%h make=%b ext=%b count=%0d required 1/1c/1/0/1",
               ev_valid, ev_keycode, ev_make, ev_ext, count);
    end
    pop_one();
    checks++;
    if (count !== '0 || ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL single pop: count=%0d valid=%b required 0/0", count, ev_valid);
    end
  endtask

  task automatic test_wrap_order();
    logic [7:0] e;
    push_n(8'h01, 5);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (ev_keycode !== e) begin
        errors++;
        $display("FAIL wrap early pop: keycode=%h required %h", ev_keycode, e);
      end
      pop_one();
    end
    push_n(8'h06, 6);
    checks++;
    if (count !== CW'(8)) begin
      errors++;
      $display("FAIL wrap count: count=%0d required 8", count);
    end
    drain_and_check("wrap");
  endtask

  task automatic test_overflow();
    int cc;
    push_n(8'h20, 8);
    for (int i = 0; i < 3; i++) begin
      send_event(8'hE0 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, cc);
      checks++;
      if (cc !== 1) begin
        errors++;
        $display("FAIL overflow clear pulse %0d: cycles=%0d required 1", i, cc);
      end
    end
    checks++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd3 || count !== CW'(8) || ev_keycode !== 8'h20) begin
      errors++;
      $display("FAIL overflow state: ovf=%b drop=%0d count=%0d head=%h required 1/3/8/20",
               overflow, drop_cnt, count, ev_keycode);
    end
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL overflow clr: ovf=%b drop=%0d required 0/0", overflow, drop_cnt);
    end
  endtask

  // Entered with the FIFO full of 0x20..0x27 and no drops recorded.
  task automatic test_full_with_pop();
    int cc;
    send_event(8'hF1, 1'b0, 1'b1, 1'b1, 1'b0, cc);
    void'(exp_q.pop_front());
    checks++;
    if (drop_cnt !== 8'd1 || overflow !== 1'b1 || count !== CW'(7) || ev_keycode !== 8'h21) begin
      errors++;
      $display("FAIL full+pop: drop=%0d ovf=%b count=%0d head=%h required 1/1/7/21",
               drop_cnt, overflow, count, ev_keycode);
    end
    push_n(8'h28, 1);
    send_event(8'hF2, 1'b0, 1'b1, 1'b0, 1'b1, cc);
    checks++;
    if (drop_cnt !== 8'd1 || overflow !== 1'b1 || count !== CW'(8)) begin
      errors++;
      $display("FAIL drop vs clr: drop=%0d ovf=%b count=%0d required 1/1/8",
               drop_cnt, overflow, count);
    end
    drain_and_check("full_pop");
  endtask

  task automatic test_reset_mid();
    got_one = 1'b1; keycode = 8'h55; ext = 1'b0; make = 1'b1;
    @(negedge clk);
    checks++;
    if (clear !== 1'b1) begin
      errors++;
      $display("FAIL mid reset setup: clear=%b required 1", clear);
    end
    reset_n = 1'b0;
    got_one = 1'b0;
    @(negedge clk);
    checks++;
    if (clear !== 1'b0 || count !== '0 || ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid reset: clear=%b count=%0d valid=%b required 0/0/0",
               clear, count, ev_valid);
    end
    reset_n = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cc;
    push_n(8'h31, 2);
    send_event(8'h33, 1'b0, 1'b1, 1'b1, 1'b0, cc);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h33);
    checks++;
    if (count !== CW'(2) || ev_keycode !== 8'h32) begin
      errors++;
      $display("FAIL push+pop: count=%0d head=%h required 2/32", count, ev_keycode);
    end
    drain_and_check("push_pop");
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap_order();
    test_overflow();
    test_full_with_pop();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
